ofmap_writer: RTL
=================

# ofmap_writer

Write-back engine at the ofmap end of the output datapath. It accepts the selected ReLU, accumulator or pool result one element per cycle over a valid/ready handshake. It packs `PACK` elements into one ofmap SRAM line and issues line writes at sequential addresses from a programmed base. It flushes a zero-padded partial line at end of layer and pulses `done`.

## Interface
Parameters:
- `DATA_WID`, default `` `psum_wid ``: element width, equal to the output-mux data width.
- `PACK`, default 4: elements per SRAM line (power of two, ≥2).
- `ADDR_WID`, default 12: SRAM line-address width.
- `LEN_WID`, default 16: element-count width.

Ports:
- `clk` in 1: clock. One clock domain; everything is on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle layer start; only honoured in IDLE.
- `base_addr` in `ADDR_WID`: first line address; sampled on `start`.
- `length` in `LEN_WID`: element count for the layer; sampled on `start`.
- `in_data` in `DATA_WID`: element from the output mux.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: writer accepts `in_data` this cycle.
- `sram_we` out 1: line write strobe.
- `sram_addr` out `ADDR_WID`: line address.
- `sram_wdata` out `PACK*DATA_WID`: line data; element 0 sits in the LSBs.
- `sram_ready` in 1: SRAM accepts the write this cycle.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle end-of-layer pulse.
- `stall_cnt` out 32: present only with `OFMAP_PERF_EN`.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- **IDLE**
  - On `start` with `length` ≠ 0: latch `base_addr` and `length`, clear the line buffer, set `slot` = 0, go to RUN.
  - On `start` with `length` = 0: go straight to DONE; no write is issued.
- **RUN**
  - An element is accepted when `in_valid && in_ready`. It is stored at `slot`; `slot` increments and the remaining count decrements.
  - When the accepted element fills slot `PACK-1`, the line is complete: the line buffer moves to an output holding register and `sram_we` is raised.
  - When the accepted element is the last of the layer and does not fill slot `PACK-1`, go to FLUSH. Unwritten slots are zero.
  - When the last element completes a line, go to DONE once that write is accepted.
- **`in_ready` rule:** `in_ready` = (state == RUN) && !(`sram_we` && !`sram_ready`). A stalled write blocks input, because the line buffer is reused.
- **FLUSH:** raise `sram_we` with the zero-padded partial line. When the write is accepted, go to DONE.
- **DONE:** assert `done` for one cycle, then go to IDLE.
- **Write handshake:** `sram_we`, `sram_addr` and `sram_wdata` are held stable until `sram_ready` is high. After each accepted write, `sram_addr` increments by 1, wrapping modulo 2^`ADDR_WID` with no error.
- `start` while `busy` is ignored.
- Input and write boundary conditions:
  - `in_valid` outside RUN is ignored.
  - When `sram_ready` is high in the same cycle that a new line completes, the old write retires and the new write is presented the next cycle; no bubble is required.
- Reset at any point, including mid-layer or mid-write, aborts the layer and discards the partial line. No `done` pulse is produced.

## Timing
- Reset values:
  - `in_ready`, `sram_we`, `busy` and `done` are 0.
  - `sram_addr` and `sram_wdata` are 0.
  - `stall_cnt` is 0.
  - State is IDLE.
- `busy` rises the cycle after `start`. `in_ready` can be high in the first RUN cycle.
- `sram_we` rises the cycle after the element that completes a line is accepted, so the write latency is 1 cycle.
- `done` pulses 1 cycle after the final write is accepted. For `length` = 0, `done` pulses 1 cycle after `start`.
- Peak throughput: 1 element/cycle when `sram_ready` is held high.

## Configuration
- Macro `OFMAP_PERF_EN`.
  - **Defined:** output port `stall_cnt` exists. It is cleared on `start` and increments every cycle that `sram_we && !sram_ready`. It holds its value after `done` and saturates at all-ones.
  - **Undefined:** the port and the counter logic are absent, and the other behaviour is identical.

## Test plan
- `PACK`=4, `base_addr`=0x010, `length`=8, elements 1..8, `sram_ready`=1 → writes {4,3,2,1}@0x010 and {8,7,6,5}@0x011; `done` pulses 1 cycle after the second write.
- `length`=6, elements 1..6 → second write is {0,0,6,5}@0x011 (via FLUSH), followed by `done`.
- `length`=4 and `sram_ready`=0 for 3 cycles → `sram_we`/`sram_addr`/`sram_wdata` stay constant and `in_ready` stays 0 for those cycles; with `OFMAP_PERF_EN`, `stall_cnt` = 3.
- `base_addr` = all-ones, `length`=8 → second write goes to address 0x000.
- `length`=0 → no `sram_we`; `done` pulses 1 cycle after `start`. A `start` issued while `busy` is ignored.
- `rst_n` dropped mid-layer after 2 elements → all outputs return to reset values immediately. A new `start` after reset writes from the new `base_addr` with no stale data.

Source files
------------

// File: rtl/ofmap_writer.sv
// ofmap_writer: packs output elements into SRAM lines and writes them back.
// Build with OFMAP_PERF_EN defined to add the stall_cnt write-stall counter.
`ifndef PSUM_WID
`define PSUM_WID 32
`endif

module ofmap_writer #(
    parameter int DATA_WID = `PSUM_WID,
    parameter int PACK     = 4,
    parameter int ADDR_WID = 12,
    parameter int LEN_WID  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_WID-1:0]      base_addr,
    input  logic [LEN_WID-1:0]       length,
    input  logic [DATA_WID-1:0]      in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     sram_we,
    output logic [ADDR_WID-1:0]      sram_addr,
    output logic [PACK*DATA_WID-1:0] sram_wdata,
    input  logic                     sram_ready,
    output logic                     busy,
    output logic                     done
`ifdef OFMAP_PERF_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);
    localparam int SLOT_WID = $clog2(PACK);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    typedef logic [PACK-1:0][DATA_WID-1:0] line_t;

    state_t              state_q, state_d;
    logic [SLOT_WID-1:0] slot_q, slot_d;
    logic [LEN_WID-1:0]  rem_q, rem_d;
    line_t               line_q, line_d;
    line_t               wdata_q, wdata_d;
    logic [ADDR_WID-1:0] addr_q, addr_d;
    logic                we_q, we_d;

    line_t merged;
    logic  accept;
    logic  wr_ack;
    logic  last_elem;
    logic  line_full;

    // A pending write that the SRAM refuses blocks input: the line buffer is reused.
    assign in_ready  = (state_q == RUN) && !(we_q && !sram_ready);
    assign accept    = in_valid && in_ready;
    assign wr_ack    = we_q && sram_ready;
    assign last_elem = (rem_q == LEN_WID'(1));
    assign line_full = (slot_q == SLOT_WID'(PACK - 1));

    assign sram_we    = we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

    // Current line with the incoming element dropped into its slot.
    always_comb begin
        merged         = line_q;
        merged[slot_q] = in_data;
    end

    // Next-state, packing and write-issue logic.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        rem_d   = rem_q;
        line_d  = line_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        we_d    = we_q;

        if (wr_ack) begin
            we_d   = 1'b0;
            addr_d = addr_q + ADDR_WID'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        addr_d  = base_addr;
                        rem_d   = length;
                        line_d  = '0;
                        slot_d  = '0;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    slot_d = slot_q + SLOT_WID'(1);
                    rem_d  = rem_q - LEN_WID'(1);
                    if (line_full || last_elem) begin
                        wdata_d = merged;
                        we_d    = 1'b1;
                        line_d  = '0;
                    end else begin
                        line_d = merged;
                    end
                    // FLUSH drains the final write, full or zero-padded.
                    if (last_elem) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (wr_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any layer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slot_q  <= '0;
            rem_q   <= '0;
            line_q  <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            rem_q   <= rem_d;
            line_q  <= line_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
        end
    end

`ifdef OFMAP_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Count cycles a write waits on the SRAM; saturates, cleared by a new layer.
    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && start) begin
            stall_d = '0;
        end else if (we_q && !sram_ready && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
